// File: rtl/tx_sched_if.sv
// -----------------------------------------------------------------------------
// tx_sched_if
//
// Bundles the word-producer side (readback and sample ports) and the byte-wide
// transceiver side of the transmit scheduler.
//
// Signal names keep the direction as seen from the scheduler:
//   _i : driven by the producers / transceiver, read by the scheduler
//   _o : driven by the scheduler
//
// Modports:
//   slave  : the scheduler itself (tx_sched)
//   master : whatever drives the producers/transceiver side (system or bench)
//
// Signals:
//   rb_tx_i    [8*BYTES] readback word
//   rb_stb_i             readback word valid, one-cycle pulse
//   rb_rdy_o             readback holding register empty
//   smp_tx_i   [8*BYTES] sample word
//   smp_en_i   [BYTES]   per-byte send enable for the sample word
//   smp_stb_i            sample word valid, one-cycle pulse
//   smp_rdy_o            sample holding register empty
//   smp_ovf_o            sticky: sample strobe arrived while register full
//   tx_rdy_i             transceiver can accept a byte
//   tx_data_o  [8]       byte to transmit
//   tx_stb_o             byte strobe toward the transceiver
//   busy_o               a word is being serialized
//   done_o               pulse when the last byte position has been handled
// -----------------------------------------------------------------------------
interface tx_sched_if #(
  parameter int BYTES = 4
);
  logic [8*BYTES-1:0] rb_tx_i;
  logic               rb_stb_i;
  logic               rb_rdy_o;

  logic [8*BYTES-1:0] smp_tx_i;
  logic [BYTES-1:0]   smp_en_i;
  logic               smp_stb_i;
  logic               smp_rdy_o;
  logic               smp_ovf_o;

  logic               tx_rdy_i;
  logic [7:0]         tx_data_o;
  logic               tx_stb_o;
  logic               busy_o;
  logic               done_o;

  modport slave (
    input  rb_tx_i, rb_stb_i,
    output rb_rdy_o,
    input  smp_tx_i, smp_en_i, smp_stb_i,
    output smp_rdy_o, smp_ovf_o,
    input  tx_rdy_i,
    output tx_data_o, tx_stb_o, busy_o, done_o
  );

  modport master (
    output rb_tx_i, rb_stb_i,
    input  rb_rdy_o,
    output smp_tx_i, smp_en_i, smp_stb_i,
    input  smp_rdy_o, smp_ovf_o,
    output tx_rdy_i,
    input  tx_data_o, tx_stb_o, busy_o, done_o
  );
endinterface

// File: rtl/tx_sched.sv
// -----------------------------------------------------------------------------
// tx_sched
//
// Transmit scheduler between two 32-bit word producers (ID/metadata readback,
// sample controller) and a byte-wide UART transmitter. Each producer owns a
// one-word holding register; a fixed-priority arbiter (readback first) hands
// full registers to a serializer that emits the word LSB-first, one byte at a
// time, under a per-byte enable mask. Only one byte is in flight: after every
// strobe the FSM spends one GAP cycle so the transceiver can drop tx_rdy_i.
//
// Ports:
//   clk_i  system clock
//   rst_i  asynchronous active-high reset
//   clr_i  synchronous clear, same effect as reset
//   bus    tx_sched_if.slave (producer ports, transceiver handshake, status)
// -----------------------------------------------------------------------------
module tx_sched #(
  parameter int BYTES = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,
  tx_sched_if.slave   bus
);

  localparam int WW = 8 * BYTES;
  localparam int IW = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(BYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t            state_q,      state_d;
  logic [IW-1:0]     idx_q,        idx_d;
  logic [WW-1:0]     shift_q,      shift_d;
  logic [BYTES-1:0]  mask_q,       mask_d;

  logic [WW-1:0]     rb_word_q,    rb_word_d;
  logic              rb_full_q,    rb_full_d;

  logic [WW-1:0]     smp_word_q,   smp_word_d;
  logic [BYTES-1:0]  smp_mask_q,   smp_mask_d;
  logic              smp_full_q,   smp_full_d;
  logic              smp_ovf_q,    smp_ovf_d;

  logic              tx_stb;
  logic              done;
  logic              is_last;
  logic              cur_en;

  // ---------------------------------------------------------------------------
  // Byte view of the shift word; tx_data_o is a pure mux on the registered
  // index, so it stays stable for as long as the FSM stalls in SEND.
  // ---------------------------------------------------------------------------
  logic [7:0] shift_bytes [BYTES];

  for (genvar gi = 0; gi < BYTES; gi++) begin : g_bytes
    assign shift_bytes[gi] = shift_q[8*gi +: 8];
  end

  assign is_last = (idx_q == LAST_IDX);
  assign cur_en  = mask_q[idx_q];

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    mask_d     = mask_q;
    rb_word_d  = rb_word_q;
    rb_full_d  = rb_full_q;
    smp_word_d = smp_word_q;
    smp_mask_d = smp_mask_q;
    smp_full_d = smp_full_q;
    smp_ovf_d  = smp_ovf_q;
    tx_stb     = 1'b0;
    done       = 1'b0;

    // Capture decisions look only at the registered full flags. A register
    // being drained this cycle is still full, so a coincident strobe is
    // dropped; drain and capture can therefore never collide.
    if (bus.rb_stb_i && !rb_full_q) begin
      rb_word_d = bus.rb_tx_i;
      rb_full_d = 1'b1;
    end

    if (bus.smp_stb_i) begin
      if (!smp_full_q) begin
        smp_word_d = bus.smp_tx_i;
        smp_mask_d = bus.smp_en_i;
        smp_full_d = 1'b1;
      end else begin
        smp_ovf_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        // Fixed priority: readback always beats sample.
        if (rb_full_q) begin
          shift_d   = rb_word_q;
          mask_d    = '1;
          rb_full_d = 1'b0;
          idx_d     = '0;
          state_d   = SEND;
        end else if (smp_full_q) begin
          shift_d    = smp_word_q;
          mask_d     = smp_mask_q;
          smp_full_d = 1'b0;
          idx_d      = '0;
          state_d    = SEND;
        end
      end

      SEND: begin
        if (!cur_en) begin
          // Disabled byte position: consumes one cycle, no strobe.
          if (is_last) begin
            done    = 1'b1;
            state_d = IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else if (bus.tx_rdy_i) begin
          tx_stb  = 1'b1;
          state_d = GAP;
        end
      end

      GAP: begin
        // tx_rdy_i is deliberately ignored here: the transceiver only
        // drops it the cycle after accepting a byte.
        if (is_last) begin
          done    = 1'b1;
          state_d = IDLE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = SEND;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Synchronous clear overrides everything, including captures and the
    // sticky overflow flag.
    if (clr_i) begin
      state_d    = IDLE;
      idx_d      = '0;
      shift_d    = '0;
      mask_d     = '0;
      rb_word_d  = '0;
      rb_full_d  = 1'b0;
      smp_word_d = '0;
      smp_mask_d = '0;
      smp_full_d = 1'b0;
      smp_ovf_d  = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      shift_q    <= '0;
      mask_q     <= '0;
      rb_word_q  <= '0;
      rb_full_q  <= 1'b0;
      smp_word_q <= '0;
      smp_mask_q <= '0;
      smp_full_q <= 1'b0;
      smp_ovf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      mask_q     <= mask_d;
      rb_word_q  <= rb_word_d;
      rb_full_q  <= rb_full_d;
      smp_word_q <= smp_word_d;
      smp_mask_q <= smp_mask_d;
      smp_full_q <= smp_full_d;
      smp_ovf_q  <= smp_ovf_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.rb_rdy_o  = !rb_full_q;
  assign bus.smp_rdy_o = !smp_full_q;
  assign bus.smp_ovf_o = smp_ovf_q;
  assign bus.tx_data_o = shift_bytes[idx_q];
  assign bus.tx_stb_o  = tx_stb;
  assign bus.busy_o    = (state_q != IDLE);
  assign bus.done_o    = done;

endmodule

// File: tb/tb_tx_sched.sv
// -----------------------------------------------------------------------------
// tb_tx_sched
//
// Directed bench for tx_sched. A negedge monitor logs every strobed byte with
// its cycle number and counts done_o pulses; each scenario then compares the
// logged activity against hand-computed bytes and cycle offsets.
// Cycle numbering: cycle 0 is the cycle in which a word strobe is driven.
// -----------------------------------------------------------------------------
module tb_tx_sched;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b0;

  always #5 clk = ~clk;

  tx_sched_if #(.BYTES(4)) bus ();

  tx_sched #(.BYTES(4)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .clr_i (clr),
    .bus   (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  // Monitor: sole writer of the activity log.
  logic [7:0] got_q  [$];
  int         scyc_q [$];
  int         done_cnt = 0;
  int         done_cyc = -1;

  always @(negedge clk) begin
    if (bus.tx_stb_o) begin
      got_q.push_back(bus.tx_data_o);
      scyc_q.push_back(cyc);
    end
    if (bus.done_o) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
  end

  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: 0x%0h", tag, got);
    end
  endtask

  function automatic logic [31:0] byte_at(int i);
    if (i < got_q.size()) return {24'h0, got_q[i]};
    return 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] scyc_at(int i);
    if (i < scyc_q.size()) return scyc_q[i];
    return 32'hFFFF_FFFF;
  endfunction

  // Advance to the drive point (1 time unit after posedge) of cycle t.
  task automatic to_cyc(int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Bounded wait until both registers are empty and the serializer is idle.
  task automatic wait_idle(string tag);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.rb_rdy_o && bus.smp_rdy_o && !bus.busy_o) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq({tag, "_idle"}, {31'h0, ok}, 32'h1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int b, d, c0, bad;
  logic [7:0] exp_id [4];
  logic [7:0] exp_arb [8];
  logic [7:0] exp_ovf [8];
  logic [7:0] exp_bp [4];

  initial begin
    exp_id  = '{8'h31, 8'h41, 8'h4C, 8'h53};
    exp_arb = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'hB1, 8'hB2, 8'hB3};
    exp_ovf = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hB1, 8'hB2, 8'hB3, 8'hB4};
    exp_bp  = '{8'h21, 8'h43, 8'h65, 8'h87};

    bus.rb_tx_i   = '0;
    bus.rb_stb_i  = 1'b0;
    bus.smp_tx_i  = '0;
    bus.smp_en_i  = '0;
    bus.smp_stb_i = 1'b0;
    bus.tx_rdy_i  = 1'b1;

    // ---------------- reset state ----------------
    @(negedge clk);
    check_eq("rst_rb_rdy",  {31'h0, bus.rb_rdy_o},  32'h1);
    check_eq("rst_smp_rdy", {31'h0, bus.smp_rdy_o}, 32'h1);
    check_eq("rst_data",    {24'h0, bus.tx_data_o}, 32'h0);
    check_eq("rst_stb",     {31'h0, bus.tx_stb_o},  32'h0);
    check_eq("rst_busy",    {31'h0, bus.busy_o},    32'h0);
    check_eq("rst_done",    {31'h0, bus.done_o},    32'h0);
    check_eq("rst_ovf",     {31'h0, bus.smp_ovf_o}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    to_cyc(cyc + 2);

    // ---------------- ID readback ----------------
    b = got_q.size(); d = done_cnt; c0 = cyc;
    bus.rb_tx_i  = 32'h534C_4131;
    bus.rb_stb_i = 1'b1;
    to_cyc(c0 + 1);
    bus.rb_stb_i = 1'b0;
    @(negedge clk);
    check_eq("id_rb_full_c1", {31'h0, bus.rb_rdy_o}, 32'h0);
    to_cyc(c0 + 10);
    @(negedge clk);
    check_eq("id_busy_c10", {31'h0, bus.busy_o}, 32'h0);
    check_eq("id_nbytes", got_q.size() - b, 4);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("id_byte%0d", i), byte_at(b + i), {24'h0, exp_id[i]});
      check_eq($sformatf("id_cyc%0d", i), scyc_at(b + i) - c0, 2 + 2*i);
    end
    check_eq("id_ndone", done_cnt - d, 1);
    check_eq("id_done_cyc", done_cyc - c0, 9);
    to_cyc(cyc + 2);

    // ---------------- byte mask 0101 ----------------
    b = got_q.size(); d = done_cnt; c0 = cyc;
    bus.smp_tx_i  = 32'h4433_2211;
    bus.smp_en_i  = 4'b0101;
    bus.smp_stb_i = 1'b1;
    to_cyc(c0 + 1);
    bus.smp_stb_i = 1'b0;
    wait_idle("mask");
    check_eq("mask_nbytes", got_q.size() - b, 2);
    check_eq("mask_byte0", byte_at(b), 32'h11);
    check_eq("mask_byte1", byte_at(b + 1), 32'h33);
    check_eq("mask_cyc0", scyc_at(b) - c0, 2);
    check_eq("mask_cyc1", scyc_at(b + 1) - c0, 5);
    check_eq("mask_ndone", done_cnt - d, 1);
    check_eq("mask_done_cyc", done_cyc - c0, 7);

    // ---------------- all-zero mask ----------------
    b = got_q.size(); d = done_cnt; c0 = cyc;
    bus.smp_tx_i  = 32'hDEAD_BEEF;
    bus.smp_en_i  = 4'b0000;
    bus.smp_stb_i = 1'b1;
    to_cyc(c0 + 1);
    bus.smp_stb_i = 1'b0;
    wait_idle("zmask");
    check_eq("zmask_nbytes", got_q.size() - b, 0);
    check_eq("zmask_ndone", done_cnt - d, 1);
    check_eq("zmask_done_cyc", done_cyc - c0, 5);

    // ---------------- arbitration ----------------
    b = got_q.size(); d = done_cnt; c0 = cyc;
    bus.rb_tx_i   = 32'hA3A2_A1A0;
    bus.rb_stb_i  = 1'b1;
    bus.smp_tx_i  = 32'hB3B2_B1B0;
    bus.smp_en_i  = 4'b1111;
    bus.smp_stb_i = 1'b1;
    to_cyc(c0 + 1);
    bus.rb_stb_i  = 1'b0;
    bus.smp_stb_i = 1'b0;
    to_cyc(c0 + 2);
    @(negedge clk);
    check_eq("arb_rb_rdy_c2",  {31'h0, bus.rb_rdy_o},  32'h1);
    check_eq("arb_smp_rdy_c2", {31'h0, bus.smp_rdy_o}, 32'h0);
    to_cyc(c0 + 10);
    @(negedge clk);
    check_eq("arb_smp_rdy_c10", {31'h0, bus.smp_rdy_o}, 32'h0);
    to_cyc(c0 + 11);
    @(negedge clk);
    check_eq("arb_smp_rdy_c11", {31'h0, bus.smp_rdy_o}, 32'h1);
    wait_idle("arb");
    check_eq("arb_nbytes", got_q.size() - b, 8);
    for (int i = 0; i < 8; i++)
      check_eq($sformatf("arb_byte%0d", i), byte_at(b + i), {24'h0, exp_arb[i]});
    check_eq("arb_b0_cyc", scyc_at(b + 4) - c0, 11);
    check_eq("arb_ndone", done_cnt - d, 2);

    // ---------------- overflow ----------------
    b = got_q.size(); d = done_cnt; c0 = cyc;
    bus.smp_tx_i  = 32'hA4A3_A2A1;
    bus.smp_en_i  = 4'b1111;
    bus.smp_stb_i = 1'b1;
    to_cyc(c0 + 1);
    bus.smp_stb_i = 1'b0;
    to_cyc(c0 + 2);
    bus.smp_tx_i  = 32'hB4B3_B2B1;
    bus.smp_stb_i = 1'b1;
    to_cyc(c0 + 3);
    bus.smp_stb_i = 1'b0;
    @(negedge clk);
    check_eq("ovf_before", {31'h0, bus.smp_ovf_o}, 32'h0);
    to_cyc(c0 + 4);
    bus.smp_tx_i  = 32'hC4C3_C2C1;
    bus.smp_stb_i = 1'b1;
    to_cyc(c0 + 5);
    bus.smp_stb_i = 1'b0;
    @(negedge clk);
    check_eq("ovf_set", {31'h0, bus.smp_ovf_o}, 32'h1);
    wait_idle("ovf");
    check_eq("ovf_nbytes", got_q.size() - b, 8);
    for (int i = 0; i < 8; i++)
      check_eq($sformatf("ovf_byte%0d", i), byte_at(b + i), {24'h0, exp_ovf[i]});
    check_eq("ovf_ndone", done_cnt - d, 2);
    to_cyc(cyc + 5);
    @(negedge clk);
    check_eq("ovf_sticky", {31'h0, bus.smp_ovf_o}, 32'h1);
    @(posedge clk);
    #1;
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    @(negedge clk);
    check_eq("ovf_cleared", {31'h0, bus.smp_ovf_o}, 32'h0);
    to_cyc(cyc + 2);

    // ---------------- backpressure ----------------
    b = got_q.size(); d = done_cnt; c0 = cyc; bad = 0;
    bus.rb_tx_i  = 32'h8765_4321;
    bus.rb_stb_i = 1'b1;
    to_cyc(c0 + 1);
    bus.rb_stb_i = 1'b0;
    to_cyc(c0 + 3);
    bus.tx_rdy_i = 1'b0;
    for (int k = 4; k <= 12; k++) begin
      to_cyc(c0 + k);
      @(negedge clk);
      if (bus.tx_stb_o !== 1'b0 || bus.tx_data_o !== 8'h43) bad++;
    end
    check_eq("bp_stall_held", bad, 0);
    to_cyc(c0 + 13);
    bus.tx_rdy_i = 1'b1;
    wait_idle("bp");
    check_eq("bp_nbytes", got_q.size() - b, 4);
    for (int i = 0; i < 4; i++)
      check_eq($sformatf("bp_byte%0d", i), byte_at(b + i), {24'h0, exp_bp[i]});
    check_eq("bp_cyc1", scyc_at(b + 1) - c0, 13);
    check_eq("bp_ndone", done_cnt - d, 1);

    // ---------------- reset mid-word ----------------
    b = got_q.size(); d = done_cnt; c0 = cyc;
    bus.rb_tx_i   = 32'h0D0C_0B0A;
    bus.rb_stb_i  = 1'b1;
    bus.smp_tx_i  = 32'h5A5A_5A5A;
    bus.smp_en_i  = 4'b1111;
    bus.smp_stb_i = 1'b1;
    to_cyc(c0 + 1);
    bus.rb_stb_i  = 1'b0;
    bus.smp_stb_i = 1'b0;
    to_cyc(c0 + 5);
    rst = 1'b1;
    #1;
    check_eq("mrst_busy",    {31'h0, bus.busy_o},    32'h0);
    check_eq("mrst_stb",     {31'h0, bus.tx_stb_o},  32'h0);
    check_eq("mrst_data",    {24'h0, bus.tx_data_o}, 32'h0);
    check_eq("mrst_done",    {31'h0, bus.done_o},    32'h0);
    check_eq("mrst_rb_rdy",  {31'h0, bus.rb_rdy_o},  32'h1);
    check_eq("mrst_smp_rdy", {31'h0, bus.smp_rdy_o}, 32'h1);
    to_cyc(c0 + 7);
    rst = 1'b0;
    to_cyc(c0 + 40);
    @(negedge clk);
    check_eq("mrst_nbytes", got_q.size() - b, 2);
    check_eq("mrst_byte0", byte_at(b), 32'h0A);
    check_eq("mrst_byte1", byte_at(b + 1), 32'h0B);
    check_eq("mrst_ndone", done_cnt - d, 0);
    check_eq("mrst_busy_after", {31'h0, bus.busy_o}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tx_sched.md
# tx_sched

Transmit scheduler between the 32-bit word producers (ID/metadata readback, sample controller) and the byte-wide UART transmitter. It buffers one word per requester and arbitrates between them with fixed priority. Each winning word is serialized LSB-first into bytes under a per-byte enable mask, with a one-byte-in-flight handshake toward the transceiver.

## Interface
- BYTES, 4, bytes per word; word width is 8*BYTES and mask width is BYTES.
- clk_i  in  1  system clock.
- rst_i  in  1  reset, asynchronous, active-high.
- clr_i  in  1  synchronous clear. Same effect as reset, sampled on clk_i.
- rb_tx_i  in  8*BYTES  readback word.
- rb_stb_i  in  1  readback word valid. One-cycle pulse.
- rb_rdy_o  out  1  readback holding register empty.
- smp_tx_i  in  8*BYTES  sample word.
- smp_en_i  in  BYTES  per-byte send enable for the sample word. Bit k enables byte k.
- smp_stb_i  in  1  sample word valid. One-cycle pulse.
- smp_rdy_o  out  1  sample holding register empty.
- smp_ovf_o  out  1  sticky flag: a sample strobe arrived while the sample holding register was full.
- tx_rdy_i  in  1  transceiver can accept a byte.
- tx_data_o  out  8  byte to transmit.
- tx_stb_o  out  1  byte strobe toward the transceiver.
- busy_o  out  1  a word is being serialized.
- done_o  out  1  one-cycle pulse when the last byte position of a word has been handled.

## Operation
- Holding registers:
  - Readback register: word, full flag. Mask is forced to all ones.
  - Sample register: word, smp_en_i mask, full flag.
  - rb_rdy_o = !rb_full and smp_rdy_o = !smp_full, both combinational.
- Capture rules:
  - A strobe with its rdy high captures the word on the edge and sets full.
  - A strobe with its rdy low is ignored. For the sample port it also sets smp_ovf_o.
  - A strobe in the same cycle that IDLE drains that register is also ignored, because rdy was low in that cycle.
- FSM states: IDLE, SEND, GAP.
- IDLE:
  - If either register is full, the next edge does all of the following: load the shift word and mask from the winner, clear the winner's full flag, set idx=0, go to SEND.
  - Readback always wins over sample.
- SEND:
  - If mask[idx]=0: skip. idx increments; if idx=BYTES-1, done_o=1 and go to IDLE. No strobe is issued.
  - Otherwise, if tx_rdy_i=1: tx_stb_o=1 this cycle, then go to GAP.
  - Otherwise: wait in SEND.
- GAP:
  - Lasts exactly one cycle. tx_rdy_i is ignored, because the transceiver drops it the cycle after accepting.
  - If idx=BYTES-1: done_o=1 and go to IDLE. Otherwise idx increments and go to SEND.
- Datapath outputs:
  - tx_data_o = shift word byte idx, i.e. bits [8*idx+7 : 8*idx], combinational from registers.
  - tx_stb_o = (state==SEND) & mask[idx] & tx_rdy_i.
  - busy_o = (state != IDLE).
- All-zero mask: the word takes BYTES SEND cycles, emits no strobes, and pulses done_o once.
- smp_ovf_o is cleared only by rst_i or clr_i.

## Timing
- Reset or clr_i: state=IDLE, idx=0, both full flags=0, shift word=0, mask=0, smp_ovf_o=0. Output values:
  - tx_data_o=0x00, tx_stb_o=0, busy_o=0, done_o=0.
  - rb_rdy_o=1, smp_rdy_o=1.
- Reset mid-word: the remaining bytes are lost with no done_o pulse. Both buffered words are discarded.
- Latency, with a strobe at cycle 0 into an empty register and the FSM in IDLE:
  - Full at cycle 1, SEND at cycle 2.
  - First tx_stb_o at cycle 2 if tx_rdy_i=1.
- Throughput with tx_rdy_i held high:
  - One byte every 2 cycles (SEND, GAP).
  - A full 4-byte word occupies 8 cycles. done_o is high in the 8th cycle, i.e. the last GAP.
  - The next buffered word enters SEND 2 cycles after done_o (one IDLE cycle).
- A register drained at the IDLE→SEND edge can be refilled from the following cycle. One word can therefore be buffered per requester while another is serialized.
- tx_rdy_i low in SEND stalls indefinitely. tx_data_o is held stable throughout the stall.

## Test plan
- ID readback: rb_tx_i=0x534C4131 ("SLA1") with tx_rdy_i=1 → tx_data_o 0x31, 0x41, 0x4C, 0x53 on strobes at cycles 2, 4, 6, 8; done_o at cycle 9; busy_o low at cycle 10.
- Byte mask: smp_tx_i=0x44332211 with smp_en_i=4'b0101 → exactly two strobes, 0x11 then 0x33, and one done_o. A second word with smp_en_i=0 → zero strobes and one done_o.
- Arbitration: rb_stb_i and smp_stb_i in the same cycle → all readback bytes are emitted before any sample byte. smp_rdy_o stays low until the sample word is loaded.
- Overflow: sample word A in flight and sample word B buffered, then a third smp_stb_i → smp_ovf_o=1 and the third word is never transmitted. smp_ovf_o stays 1 until clr_i.
- Backpressure: tx_rdy_i=0 for 10 cycles during byte 1 → tx_stb_o stays 0 and tx_data_o is held. Bytes resume in order once tx_rdy_i rises.
- Reset mid-word: rst_i asserted after the 2nd strobe → all outputs immediately take their reset values, no done_o, and no further strobes after release.
